// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter in front of a single-port byte RAM: round-robin
// ownership with an optional lock for read-modify-write sequences.
module ram_port_arbiter #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  input  logic        lock0,
  input  logic        lock1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  rdata,
  output logic [1:0]  grant,
  output logic        busy,
  output logic [15:0] ramAddress,
  output logic [7:0]  ramDataOut,
  input  logic [7:0]  ramDataIn,
  output logic        ramReadSignal,
  output logic        ramWriteSignal
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(RD_LATENCY - 1);

  state_t      state_q, state_d;
  logic        last_owner_q, last_owner_d;
  logic        locked_q, locked_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic        lock_q, lock_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  grant_q, grant_d;
  logic        ack0_q, ack0_d, ack1_q, ack1_d;
  logic        busy_q, busy_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic        elig0, elig1, pick1, owner_lock;

  always_comb begin
    // While locked, only the current owner may be granted again.
    elig0      = req0 && (!locked_q || !owner_q);
    elig1      = req1 && (!locked_q ||  owner_q);
    pick1      = elig1 && (!elig0 || !last_owner_q);
    owner_lock = owner_q ? lock1 : lock0;

    state_d      = state_q;
    last_owner_d = last_owner_q;
    locked_d     = locked_q;
    owner_d      = owner_q;
    we_d         = we_q;
    lock_d       = lock_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rd_d         = rd_q;
    wr_d         = wr_q;

    case (state_q)
      IDLE: begin
        if (locked_q && !owner_lock) locked_d = 1'b0;
        if (elig0 || elig1) begin
          owner_d = pick1;
          we_d    = pick1 ? we1 : we0;
          addr_d  = pick1 ? addr1 : addr0;
          wdata_d = pick1 ? wdata1 : wdata0;
          lock_d  = pick1 ? lock1 : lock0;
          grant_d = {pick1, !pick1};
          rd_d    = !we_d;
          wr_d    = we_d;
          cnt_d   = CNT_INIT;
          state_d = ACCESS;
        end
      end
      ACCESS, WAIT: begin
        // Writes take one strobe cycle; reads hold the strobe until cnt hits 0.
        if (we_q || cnt_q == 4'd0) begin
          state_d = RESP;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (!we_q) rdata_d = ramDataIn;
          ack0_d  = !owner_q;
          ack1_d  = owner_q;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d  = IDLE;
        grant_d  = 2'b00;
        locked_d = lock_q;
        if (!lock_q) last_owner_d = owner_q;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      locked_q     <= 1'b0;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      lock_q       <= 1'b0;
      addr_q       <= 16'h0000;
      wdata_q      <= 8'h00;
      rdata_q      <= 8'h00;
      cnt_q        <= 4'd0;
      grant_q      <= 2'b00;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      busy_q       <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      locked_q     <= locked_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      lock_q       <= lock_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      busy_q       <= busy_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
    end
  end

  assign ack0           = ack0_q;
  assign ack1           = ack1_q;
  assign rdata          = rdata_q;
  assign grant          = grant_q;
  assign busy           = busy_q;
  assign ramAddress     = addr_q;
  assign ramDataOut     = wdata_q;
  assign ramReadSignal  = rd_q;
  assign ramWriteSignal = wr_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios then random traffic, all
// checked every cycle against a transaction-timeline reference model.
module tb_ram_port_arbiter;
  localparam int L = 3;

  logic        clk = 1'b0;
  logic        RST, req0, req1, we0, we1, lock0, lock1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        ack0, ack1, busy, ramReadSignal, ramWriteSignal;
  logic [7:0]  rdata, ramDataOut, ramDataIn;
  logic [1:0]  grant;
  logic [15:0] ramAddress;

  always #5 clk = ~clk;

  ram_port_arbiter #(.RD_LATENCY(L)) dut (
    .clk(clk), .RST(RST), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1), .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .grant(grant), .busy(busy), .ramAddress(ramAddress), .ramDataOut(ramDataOut),
    .ramDataIn(ramDataIn), .ramReadSignal(ramReadSignal), .ramWriteSignal(ramWriteSignal)
  );

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // RAM environment: data appears only in the final strobe cycle of a read.
  logic [7:0] env_mem [0:65535];
  int rd_run;
  initial begin
    rd_run = 0;
    for (int i = 0; i < 65536; i++) env_mem[i] = pat(16'(i));
    env_mem[16'h0100] = 8'h3C;
    forever begin
      @(negedge clk);
      if (ramWriteSignal) env_mem[ramAddress] = ramDataOut;
      rd_run = ramReadSignal ? rd_run + 1 : 0;
    end
  end
  assign ramDataIn = (ramReadSignal && rd_run == L) ? env_mem[ramAddress] : 8'hEE;

  // Reference model: each granted transaction is a timeline of cycles.
  logic [7:0]  ref_mem [0:65535];
  int          cyc, n_cmp, n_err;
  logic        m_last, m_locked, m_owner;
  logic        tx_valid, tx_we, tx_who;
  int          tx_start, tx_ack, idle_from;
  logic [15:0] tx_addr, m_addr;
  logic [7:0]  tx_wdata, tx_rval, m_wdata, m_rdata;
  logic [1:0]  gseq [$];
  logic [1:0]  gprev;
  int          acks0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step();
    logic e0, e1, who, lk;
    if (RST) begin
      tx_valid = 1'b0; idle_from = cyc + 1;
      m_last = 1'b1; m_locked = 1'b0; m_owner = 1'b0;
      m_rdata = 8'h00; m_addr = 16'h0000; m_wdata = 8'h00;
    end else if (cyc >= idle_from) begin
      e0 = req0 && (!m_locked || m_owner == 1'b0);
      e1 = req1 && (!m_locked || m_owner == 1'b1);
      if (e0 || e1) begin
        who      = e1 && (!e0 || m_last == 1'b0);
        tx_valid = 1'b1;
        tx_who   = who;
        tx_we    = who ? we1 : we0;
        tx_addr  = who ? addr1 : addr0;
        tx_wdata = who ? wdata1 : wdata0;
        lk       = who ? lock1 : lock0;
        tx_start = cyc + 1;
        tx_ack   = tx_we ? cyc + 2 : cyc + 1 + L;
        idle_from = tx_ack + 1;
        m_addr   = tx_addr;
        m_wdata  = tx_wdata;
        if (tx_we) ref_mem[tx_addr] = tx_wdata;
        else       tx_rval = ref_mem[tx_addr];
        m_locked = lk;
        m_owner  = who;
        if (!lk) m_last = who;
      end else if (m_locked && !(m_owner ? lock1 : lock0)) begin
        m_locked = 1'b0;
      end
    end
  endtask

  task automatic check_cycle();
    logic act, rsp;
    logic [1:0] g;
    act = tx_valid && cyc >= tx_start && cyc < tx_ack;
    rsp = tx_valid && cyc == tx_ack;
    if (rsp && !tx_we) m_rdata = tx_rval;
    g = (act || rsp) ? (tx_who ? 2'b10 : 2'b01) : 2'b00;
    chk("grant",      16'(grant),          16'(g));
    chk("busy",       16'(busy),           16'(act || rsp));
    chk("rd_strobe",  16'(ramReadSignal),  16'(act && !tx_we));
    chk("wr_strobe",  16'(ramWriteSignal), 16'(act && tx_we));
    chk("ack0",       16'(ack0),           16'(rsp && !tx_who));
    chk("ack1",       16'(ack1),           16'(rsp && tx_who));
    chk("rdata",      16'(rdata),          16'(m_rdata));
    chk("ramAddress", ramAddress,          m_addr);
    chk("ramDataOut", 16'(ramDataOut),     16'(m_wdata));
    chk("strobe_excl", 16'(ramReadSignal & ramWriteSignal), 16'd0);
    chk("grant_not_11", 16'(grant == 2'b11), 16'd0);
    if (rsp)
      $display("txn cyc=%0d req%0d %s addr=%04h data=%02h", cyc, tx_who,
               tx_we ? "WR" : "RD", tx_addr, tx_we ? tx_wdata : m_rdata);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    a = 16'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 1) a = a | 16'hFF00;
    return a;
  endfunction

  initial begin
    cyc = 0; n_cmp = 0; n_err = 0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = pat(16'(i));
    ref_mem[16'h0100] = 8'h3C;
    RST = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    tick(); tick();
    RST = 1'b0;
    tick();

    // Single write from requester 0.
    req0 = 1; we0 = 1; addr0 = 16'h0010; wdata0 = 8'hA5;
    tick();
    req0 = 0;
    chk("w_strobe", 16'(ramWriteSignal), 16'd1);
    chk("w_addr",   ramAddress,          16'h0010);
    chk("w_data",   16'(ramDataOut),     16'h00A5);
    tick();
    chk("w_ack0",   16'(ack0),           16'd1);
    tick();

    // Read from requester 1 with three-cycle latency.
    req1 = 1; we1 = 0; addr1 = 16'h0100;
    tick();
    req1 = 0;
    for (int i = 0; i < L; i++) begin
      chk("r_strobe", 16'(ramReadSignal), 16'd1);
      tick();
    end
    chk("r_ack1",  16'(ack1),  16'd1);
    chk("r_rdata", 16'(rdata), 16'h003C);
    tick();

    // Contention: both held high right after reset.
    RST = 1; tick(); RST = 0;
    req0 = 1; we0 = 1; addr0 = 16'h0020; wdata0 = 8'h11;
    req1 = 1; we1 = 1; addr1 = 16'h0021; wdata1 = 8'h22;
    gseq.delete(); gprev = 2'b00;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (grant != 2'b00 && gprev == 2'b00) gseq.push_back(grant);
      gprev = grant;
    end
    req0 = 0; req1 = 0;
    repeat (3) tick();
    chk("contend_count", 16'(gseq.size() >= 4), 16'd1);
    for (int i = 0; i < 4 && i < gseq.size(); i++)
      chk("contend_order", 16'(gseq[i]), (i % 2 == 0) ? 16'h1 : 16'h2);

    // Locked read-modify-write by requester 0 while requester 1 waits.
    RST = 1; tick(); RST = 0;
    req0 = 1; we0 = 0; addr0 = 16'h0200; lock0 = 1;
    req1 = 1; we1 = 1; addr1 = 16'h0300; wdata1 = 8'h99; lock1 = 0;
    gseq.delete(); gprev = 2'b00; acks0 = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (grant != 2'b00 && gprev == 2'b00) gseq.push_back(grant);
      gprev = grant;
      if (ack0) begin
        acks0++;
        if (acks0 == 1) begin we0 = 1; lock0 = 0; wdata0 = 8'h77; end
        else req0 = 0;
      end
      if (ack1) req1 = 0;
    end
    req0 = 0; req1 = 0; lock0 = 0;
    chk("lock_count", 16'(gseq.size()), 16'd3);
    for (int i = 0; i < 3 && i < gseq.size(); i++)
      chk("lock_order", 16'(gseq[i]), (i < 2) ? 16'h1 : 16'h2);

    // Reset while a read is waiting on the RAM.
    req0 = 1; we0 = 0; addr0 = 16'h0400;
    tick();
    req0 = 0;
    tick();
    RST = 1;
    tick();
    RST = 0;
    chk("rst_busy",  16'(busy),          16'd0);
    chk("rst_grant", 16'(grant),         16'd0);
    chk("rst_ack0",  16'(ack0),          16'd0);
    chk("rst_rdata", 16'(rdata),         16'd0);
    chk("rst_rd",    16'(ramReadSignal), 16'd0);
    chk("rst_addr",  ramAddress,         16'h0000);
    repeat (4) tick();
    req0 = 1; we0 = 1; addr0 = 16'h0400; wdata0 = 8'h5C;
    tick(); req0 = 0; repeat (3) tick();
    req0 = 1; we0 = 0;
    tick(); req0 = 0; repeat (L + 2) tick();

    // Random traffic, including occasional resets and locks.
    for (int i = 0; i < 400; i++) begin
      RST    = ($urandom_range(0, 63) == 0);
      req0   = 1'($urandom_range(0, 1));
      req1   = 1'($urandom_range(0, 1));
      we0    = 1'($urandom_range(0, 1));
      we1    = 1'($urandom_range(0, 1));
      addr0  = rand_addr();
      addr1  = rand_addr();
      wdata0 = 8'($urandom);
      wdata1 = 8'($urandom);
      lock0  = ($urandom_range(0, 3) == 0);
      lock1  = ($urandom_range(0, 3) == 0);
      tick();
    end
    RST = 0; req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
